// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared constants and types for the bit-serial subtractor
package serial_subtractor_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done request and result bundle for the serial subtractor
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow
   );

endinterface

// File: rtl/serial_subtractor_full.sv
// rtl/serial_subtractor_full.sv - full subtractor from two half subtractors and an OR
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d_ab;
   logic bout_ab;
   logic bout_in;

   half_subtractor u_hs_ab (
      .a    (a),
      .b    (b),
      .d    (d_ab),
      .bout (bout_ab)
   );

   // second stage subtracts the incoming borrow from the partial difference
   half_subtractor u_hs_in (
      .a    (d_ab),
      .b    (bin),
      .d    (d),
      .bout (bout_in)
   );

   assign bout = bout_ab | bout_in;

endmodule

// File: rtl/serial_subtractor_half.sv
// rtl/serial_subtractor_half.sv - single-bit half subtractor primitive
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned a - b, LSB first, start/done handshake
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   serial_subtractor_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-2:0]   res_sr;
   logic [WIDTH-1:0]   res_next;
   logic               bin;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   diff_q;
   logic               borrow_q;
   logic               d;
   logic               bout;

   full_subtractor u_fs (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (bin),
      .d    (d),
      .bout (bout)
   );

   // new bit enters at the MSB; after the last shift this is the full difference
   assign res_next = {d, res_sr};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         bin      <= 1'b0;
         cnt      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  a_sr  <= bus.a;
                  b_sr  <= bus.b;
                  bin   <= 1'b0;
                  cnt   <= '0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               res_sr <= res_next[WIDTH-1:1];
               bin    <= bout;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  diff_q   <= res_next;
                  borrow_q <= bout;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = (state != ST_IDLE);
   assign bus.done   = (state == ST_DONE);
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;

endmodule
